// File: rtl/soc_dbus_if.sv
// Core-side data port of soc_dbus: request strobes, address/data and the ready/read-data return.
interface soc_dbus_if;
    logic        req_r;
    logic [3:0]  req_w;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rdata;
    logic        req_ready;

    modport master (
        output req_r, req_w, req_addr, req_wdata,
        input  req_rdata, req_ready
    );

    modport slave (
        input  req_r, req_w, req_addr, req_wdata,
        output req_rdata, req_ready
    );
endinterface

// File: rtl/soc_dbus.sv
// Data-bus controller: routes core accesses to RAM (optional wait states) or to MMIO (console, exit, cycles).
// Build option: define SOC_DBUS_WDT_EN to enable the WDT_LIMIT cycle watchdog.
module soc_dbus #(
    parameter int unsigned RAM_WAIT  = 0,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [63:0] WDT_LIMIT = 64'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    soc_dbus_if.slave   bus,
    output logic        ram_r,
    output logic [3:0]  ram_w,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        brk,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic [63:0] cycles
);
    localparam logic [15:0] OFF_CONSOLE  = 16'h0000;
    localparam logic [15:0] OFF_EXIT     = 16'h0004;
    localparam logic [15:0] OFF_CYCLE_LO = 16'h0008;
    localparam logic [15:0] OFF_CYCLE_HI = 16'h000C;

    logic        halt_reg;
    logic [31:0] exit_code_reg;
    logic [63:0] cycles_reg;
    logic        con_valid_reg;
    logic [7:0]  con_data_reg;

    logic        access;
    logic        is_mmio;
    logic        live;
    logic        mmio_acc;
    logic        ram_acc;
    logic [15:0] offset;
    logic        con_wr;
    logic        exit_wr;
    logic        wdt_hit;
    logic        ram_ready;
    logic [31:0] mmio_rdata;

    // Nothing reaches RAM or MMIO while halted or while reset is held.
    assign access   = bus.req_r | (|bus.req_w);
    assign is_mmio  = (bus.req_addr[31:16] == MMIO_BASE[31:16]);
    assign offset   = bus.req_addr[15:0];
    assign live     = access & ~halt_reg & ~rst;
    assign mmio_acc = live & is_mmio;
    assign ram_acc  = live & ~is_mmio;
    assign con_wr   = mmio_acc & (offset == OFF_CONSOLE) & bus.req_w[0];
    assign exit_wr  = mmio_acc & (offset == OFF_EXIT) & (bus.req_w == 4'hF);

`ifdef SOC_DBUS_WDT_EN
    assign wdt_hit = (cycles_reg == (WDT_LIMIT - 64'd1));
`else
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        mmio_rdata = 32'h0;
        case (offset)
            OFF_EXIT:     mmio_rdata = exit_code_reg;
            OFF_CYCLE_LO: mmio_rdata = cycles_reg[31:0];
            OFF_CYCLE_HI: mmio_rdata = cycles_reg[63:32];
            default:      mmio_rdata = 32'h0;
        endcase
    end

    generate
        if (RAM_WAIT == 0) begin : g_no_wait
            assign ram_ready = ram_acc;
        end else begin : g_wait
            typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
            // Counter is loaded with N-1 so that ready lands exactly N cycles after the request.
            localparam logic [3:0] CNT_LOAD = 4'(RAM_WAIT - 1);

            state_t     state_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 4'h0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (ram_acc) begin
                                cnt_reg   <= CNT_LOAD;
                                state_reg <= (CNT_LOAD == 4'h0) ? ST_DONE : ST_WAIT;
                            end
                        end
                        ST_WAIT: begin
                            if (!ram_acc) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                cnt_reg <= cnt_reg - 4'h1;
                                if (cnt_reg == 4'h1) begin
                                    state_reg <= ST_DONE;
                                end
                            end
                        end
                        ST_DONE: state_reg <= ST_IDLE;
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end

            assign ram_ready = (state_reg == ST_DONE) & ram_acc;
        end
    endgenerate

    // Byte-write strobes only in the completing cycle, so an abandoned access never writes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_w[gi] = ram_ready & bus.req_w[gi];
        end
    endgenerate

    assign ram_r         = ram_acc & bus.req_r;
    assign ram_addr      = bus.req_addr;
    assign ram_wdata     = bus.req_wdata;
    assign bus.req_ready = mmio_acc | ram_ready;
    assign bus.req_rdata = mmio_acc ? mmio_rdata : (ram_ready ? ram_rdata : 32'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_reg      <= 1'b0;
            exit_code_reg <= 32'h0;
            cycles_reg    <= 64'h0;
            con_valid_reg <= 1'b0;
            con_data_reg  <= 8'h0;
        end else begin
            con_valid_reg <= con_wr;
            if (con_wr) begin
                con_data_reg <= bus.req_wdata[7:0];
            end
            if (!halt_reg) begin
                cycles_reg <= cycles_reg + 64'd1;
                // Explicit exit code beats breakpoint, which beats the watchdog.
                if (exit_wr) begin
                    halt_reg      <= 1'b1;
                    exit_code_reg <= bus.req_wdata;
                end else if (brk) begin
                    halt_reg      <= 1'b1;
                    exit_code_reg <= 32'hFFFF_FFFF;
                end else if (wdt_hit) begin
                    halt_reg      <= 1'b1;
                    exit_code_reg <= 32'hDEAD_0001;
                end
            end
        end
    end

    assign halt      = halt_reg;
    assign exit_code = exit_code_reg;
    assign cycles    = cycles_reg;
    assign con_valid = con_valid_reg & ~halt_reg;
    assign con_data  = con_data_reg;
endmodule

// File: tb/tb_soc_dbus.sv
// Bench for soc_dbus: one stimulus stream drives a zero-wait and a 3-wait instance against a reference model.
module tb_soc_dbus;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    bit tb_init  = 1'b1;
    bit wdt_done = 1'b0;

    logic        s_rst = 1'b1;
    logic        s_r   = 1'b0;
    logic [3:0]  s_w   = 4'h0;
    logic [31:0] s_addr  = 32'h0;
    logic [31:0] s_wdata = 32'h0;
    logic        s_brk = 1'b0;

    soc_dbus_if bus0 ();
    soc_dbus_if bus3 ();
    assign bus0.req_r = s_r;  assign bus0.req_w = s_w;
    assign bus0.req_addr = s_addr;  assign bus0.req_wdata = s_wdata;
    assign bus3.req_r = s_r;  assign bus3.req_w = s_w;
    assign bus3.req_addr = s_addr;  assign bus3.req_wdata = s_wdata;

    logic        ram_r0, ram_r3, halt0, halt3, con_valid0, con_valid3;
    logic [3:0]  ram_w0, ram_w3;
    logic [31:0] ram_addr0, ram_addr3, ram_wdata0, ram_wdata3, ram_rdata0, ram_rdata3;
    logic [31:0] exit_code0, exit_code3;
    logic [7:0]  con_data0, con_data3;
    logic [63:0] cycles0, cycles3;

    soc_dbus #(.RAM_WAIT(0)) u_dut0 (
        .clk(clk), .rst(s_rst), .bus(bus0),
        .ram_r(ram_r0), .ram_w(ram_w0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0),
        .brk(s_brk), .halt(halt0), .exit_code(exit_code0),
        .con_valid(con_valid0), .con_data(con_data0), .cycles(cycles0)
    );

    soc_dbus #(.RAM_WAIT(3)) u_dut3 (
        .clk(clk), .rst(s_rst), .bus(bus3),
        .ram_r(ram_r3), .ram_w(ram_w3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3),
        .brk(s_brk), .halt(halt3), .exit_code(exit_code3),
        .con_valid(con_valid3), .con_data(con_data3), .cycles(cycles3)
    );

    // Physical RAMs behind each instance (word index from addr[9:2]).
    logic [31:0] ram0 [256];
    logic [31:0] ram3 [256];
    assign ram_rdata0 = ram0[ram_addr0[9:2]];
    assign ram_rdata3 = ram3[ram_addr3[9:2]];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= 32'h0;
                ram3[i] <= 32'h0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_w0[b]) ram0[ram_addr0[9:2]][8*b +: 8] <= ram_wdata0[8*b +: 8];
                if (ram_w3[b]) ram3[ram_addr3[9:2]][8*b +: 8] <= ram_wdata3[8*b +: 8];
            end
        end
    end

    // DUT outputs gathered by instance index: 0 = zero-wait, 1 = three-wait.
    logic        d_ready [2];
    logic [31:0] d_rdata [2];
    logic        d_ram_r [2];
    logic [3:0]  d_ram_w [2];
    logic [31:0] d_ram_addr [2];
    logic        d_halt [2];
    logic [31:0] d_exit [2];
    logic        d_conv [2];
    logic [7:0]  d_cond [2];
    logic [63:0] d_cycles [2];
    assign d_ready[0] = bus0.req_ready;  assign d_ready[1] = bus3.req_ready;
    assign d_rdata[0] = bus0.req_rdata;  assign d_rdata[1] = bus3.req_rdata;
    assign d_ram_r[0] = ram_r0;          assign d_ram_r[1] = ram_r3;
    assign d_ram_w[0] = ram_w0;          assign d_ram_w[1] = ram_w3;
    assign d_ram_addr[0] = ram_addr0;    assign d_ram_addr[1] = ram_addr3;
    assign d_halt[0] = halt0;            assign d_halt[1] = halt3;
    assign d_exit[0] = exit_code0;       assign d_exit[1] = exit_code3;
    assign d_conv[0] = con_valid0;       assign d_conv[1] = con_valid3;
    assign d_cond[0] = con_data0;        assign d_cond[1] = con_data3;
    assign d_cycles[0] = cycles0;        assign d_cycles[1] = cycles3;

    // Reference model: ready comes when a RAM access has been held for N cycles (its "age").
    logic [63:0] m_cycles [2];
    logic        m_halt [2];
    logic [31:0] m_exit [2];
    logic        m_conv [2];
    logic [7:0]  m_cond [2];
    int          m_age [2];
    logic [31:0] m_mem [2][256];

    function automatic int f_wait(int k);
        return (k == 0) ? 0 : 3;
    endfunction
    function automatic bit f_mmio();
        return s_addr[31:16] == 16'hFFFF;
    endfunction
    function automatic bit f_live(int k);
        return !s_rst && !m_halt[k] && (s_r || (s_w != 4'h0));
    endfunction
    function automatic bit f_ram_ready(int k);
        return f_live(k) && !f_mmio() && (m_age[k] == f_wait(k));
    endfunction
    function automatic bit f_exp_ready(int k);
        return (f_live(k) && f_mmio()) || f_ram_ready(k);
    endfunction
    function automatic logic [31:0] f_exp_rdata(int k);
        if (!f_live(k)) return 32'h0;
        if (!f_mmio()) return m_mem[k][s_addr[9:2]];
        case (s_addr[15:0])
            16'h0004: return m_exit[k];
            16'h0008: return m_cycles[k][31:0];
            16'h000C: return m_cycles[k][63:32];
            default:  return 32'h0;
        endcase
    endfunction
    function automatic bit f_con_wr(int k);
        return f_live(k) && f_mmio() && (s_addr[15:0] == 16'h0000) && s_w[0];
    endfunction
    function automatic bit f_exit_wr(int k);
        return f_live(k) && f_mmio() && (s_addr[15:0] == 16'h0004) && (s_w == 4'hF);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tb_init) begin
                for (int i = 0; i < 256; i++) m_mem[k][i] <= 32'h0;
            end
            if (s_rst) begin
                m_cycles[k] <= 64'h0;
                m_halt[k]   <= 1'b0;
                m_exit[k]   <= 32'h0;
                m_conv[k]   <= 1'b0;
                m_cond[k]   <= 8'h0;
                m_age[k]    <= 0;
            end else begin
                m_conv[k] <= f_con_wr(k);
                if (f_con_wr(k)) m_cond[k] <= s_wdata[7:0];
                if (!m_halt[k]) begin
                    m_cycles[k] <= m_cycles[k] + 64'd1;
                    if (f_exit_wr(k)) begin
                        m_halt[k] <= 1'b1;
                        m_exit[k] <= s_wdata;
                    end else if (s_brk) begin
                        m_halt[k] <= 1'b1;
                        m_exit[k] <= 32'hFFFF_FFFF;
                    end
                end
                if (f_live(k) && !f_mmio()) begin
                    if (f_ram_ready(k)) begin
                        m_age[k] <= 0;
                        for (int b = 0; b < 4; b++)
                            if (s_w[b]) m_mem[k][s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                    end else begin
                        m_age[k] <= m_age[k] + 1;
                    end
                end else begin
                    m_age[k] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                p = (k == 0) ? "w0_" : "w3_";
                chk({p, "ready"}, 64'(d_ready[k]), 64'(f_exp_ready(k)));
                chk({p, "ram_r"}, 64'(d_ram_r[k]), 64'(f_live(k) && !f_mmio() && s_r));
                chk({p, "ram_w"}, 64'(d_ram_w[k]), 64'(f_ram_ready(k) ? s_w : 4'h0));
                if (f_exp_ready(k) || s_rst)
                    chk({p, "rdata"}, 64'(d_rdata[k]), 64'(f_exp_rdata(k)));
                chk({p, "ram_addr"}, 64'(d_ram_addr[k]), 64'(s_addr));
                chk({p, "halt"}, 64'(d_halt[k]), 64'(m_halt[k]));
                chk({p, "exit"}, 64'(d_exit[k]), 64'(m_exit[k]));
                chk({p, "con_valid"}, 64'(d_conv[k]), 64'(m_conv[k] && !m_halt[k]));
                chk({p, "con_data"}, 64'(d_cond[k]), 64'(m_cond[k]));
                chk({p, "cycles"}, d_cycles[k], m_cycles[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic b);
        s_r = r; s_w = w; s_addr = a; s_wdata = d; s_brk = b;
        $display("drive r=%0b w=%h addr=%h wdata=%h brk=%0b at %0t", r, w, a, d, b, $time);
    endtask

`ifdef SOC_DBUS_WDT_EN
    logic        rst_w = 1'b1;
    soc_dbus_if  busw ();
    assign busw.req_r = 1'b0;  assign busw.req_w = 4'h0;
    assign busw.req_addr = 32'h0;  assign busw.req_wdata = 32'h0;
    logic        ram_rw, halt_w, con_valid_w;
    logic [3:0]  ram_ww;
    logic [31:0] ram_addr_w, ram_wdata_w, exit_code_w;
    logic [7:0]  con_data_w;
    logic [63:0] cycles_w;

    soc_dbus #(.RAM_WAIT(0), .WDT_LIMIT(64'd50)) u_dutw (
        .clk(clk), .rst(rst_w), .bus(busw),
        .ram_r(ram_rw), .ram_w(ram_ww), .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w), .ram_rdata(32'h0),
        .brk(1'b0), .halt(halt_w), .exit_code(exit_code_w),
        .con_valid(con_valid_w), .con_data(con_data_w), .cycles(cycles_w)
    );

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_w = 1'b0;
        repeat (49) @(posedge clk);
        @(negedge clk);
        chk("wdt_pre_halt", 64'(halt_w), 64'd0);
        chk("wdt_pre_cycles", cycles_w, 64'd49);
        @(negedge clk);
        chk("wdt_halt", 64'(halt_w), 64'd1);
        chk("wdt_exit", 64'(exit_code_w), 64'hDEAD_0001);
        chk("wdt_cycles", cycles_w, 64'd50);
        repeat (5) @(negedge clk);
        chk("wdt_frozen", cycles_w, 64'd50);
        $display("watchdog sequence done at %0t", $time);
        wdt_done = 1'b1;
    end
`else
    initial wdt_done = 1'b1;
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        cmp_en  = 1'b1;
        tb_init = 1'b0;
        @(negedge clk);
        chk("rst_halt", 64'(halt3), 64'd0);
        chk("rst_cycles", cycles3, 64'd0);
        chk("rst_ready", 64'(bus0.req_ready), 64'd0);
        tick();
        s_rst = 1'b0;
        repeat (10) tick();

        // Cycle counter readback ten cycles out of reset.
        drive(1'b1, 4'h0, 32'hFFFF_0008, 32'h0, 1'b0);
        @(negedge clk);
        chk("model_cycles", m_cycles[1], 64'd10);
        chk("cycle_lo_w0", 64'(bus0.req_rdata), 64'd10);
        chk("cycle_lo_w3", 64'(bus3.req_rdata), 64'd10);
        chk("cycle_lo_ready", 64'(bus3.req_ready), 64'd1);
        tick();
        drive(1'b1, 4'h0, 32'hFFFF_000C, 32'h0, 1'b0);
        @(negedge clk);
        chk("cycle_hi", 64'(bus3.req_rdata), 64'd0);
        tick();

        // RAM write then read of 0x100.
        drive(1'b0, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_ready_w0", 64'(bus0.req_ready), 64'd1);
            chk("wr_ready_w3", 64'(bus3.req_ready), 64'(i == 3));
            chk("wr_ram_w_w3", 64'(ram_w3), (i == 3) ? 64'hF : 64'h0);
            tick();
        end
        drive(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_ready_w0", 64'(bus0.req_ready), 64'd1);
            chk("rd_data_w0", 64'(bus0.req_rdata), 64'h1234_5678);
            chk("rd_ready_w3", 64'(bus3.req_ready), 64'(i == 3));
            if (i == 3) chk("rd_data_w3", 64'(bus3.req_rdata), 64'h1234_5678);
            tick();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();

        // Read dropped after one cycle, then a fresh read must take the full three cycles.
        drive(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drop_ready", 64'(bus3.req_ready), 64'd0);
        tick();
        tick();
        drive(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("refetch_ready", 64'(bus3.req_ready), 64'(i == 3));
            tick();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        tick();

        // Console byte and an unmapped MMIO offset.
        drive(1'b0, 4'h1, 32'hFFFF_0000, 32'h0000_0041, 1'b0);
        @(negedge clk);
        chk("con_wr_ready", 64'(bus3.req_ready), 64'd1);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("con_valid", 64'(con_valid3), 64'd1);
        chk("con_data", 64'(con_data3), 64'h41);
        tick();
        drive(1'b1, 4'h0, 32'hFFFF_0010, 32'h0, 1'b0);
        @(negedge clk);
        chk("con_valid_off", 64'(con_valid3), 64'd0);
        chk("unmapped_ready", 64'(bus3.req_ready), 64'd1);
        chk("unmapped_rdata", 64'(bus3.req_rdata), 64'd0);
        tick();

        // Reset in the middle of a three-wait write to 0x200.
        drive(1'b0, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0);
        tick();
        tick();
        s_rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 64'(bus3.req_ready), 64'd0);
        chk("rstmid_ram_w", 64'(ram_w3), 64'd0);
        tick();
        s_rst = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rstmid_cycles", cycles3, 64'd0);
        repeat (4) tick();
        @(negedge clk);
        chk("rstmid_no_write", 64'(ram3[8'h80]), 64'd0);
        chk("rstmid_w0_write", 64'(ram0[8'h80]), 64'hDEAD_BEEF);
        tick();

        // EXIT write with brk in the same cycle: exit code wins, then halt is sticky.
        drive(1'b0, 4'hF, 32'hFFFF_0004, 32'h0000_0007, 1'b1);
        @(negedge clk);
        chk("exit_ready", 64'(bus3.req_ready), 64'd1);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("halt_set", 64'(halt3), 64'd1);
        chk("halt_exit", 64'(exit_code3), 64'd7);
        chk("halt_cycles", cycles3, 64'd6);
        repeat (3) tick();
        @(negedge clk);
        chk("halt_frozen", cycles3, 64'd6);
        tick();
        drive(1'b0, 4'hF, 32'h0000_0300, 32'h5555_AAAA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted_ram_w3", 64'(ram_w3), 64'd0);
            chk("halted_ram_w0", 64'(ram_w0), 64'd0);
            chk("halted_ready", 64'(bus3.req_ready), 64'd0);
            tick();
        end
        drive(1'b0, 4'hF, 32'hFFFF_0004, 32'h0000_0009, 1'b1);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("halted_exit_kept", 64'(exit_code3), 64'd7);
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        @(negedge clk);
        chk("rst_clears_halt", 64'(halt3), 64'd0);
        chk("rst_clears_exit", 64'(exit_code3), 64'd0);
        tick();

        while (!wdt_done) tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
